// File: rtl/cache_arbiter.sv
// Shares one line-wide memory port between the I-cache and D-cache, granting
// one whole line transaction at a time with round-robin on contention.
module cache_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,

    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,

    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp,

    output logic                  busy,
    output logic                  grant_d
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        I_BUSY  = 2'd1,
        D_BUSY  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t                  state;
    logic                    last_grant_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [LINE_WIDTH-1:0]   wdata_q;

    logic                    i_req;
    logic                    d_req;
    logic                    pick_d;

    assign i_req  = i_pmem_read;
    assign d_req  = d_pmem_read | d_pmem_write;
    // On a tie the side that was not served last wins.
    assign pick_d = d_req & (~i_req | ~last_grant_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            last_grant_d <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req | d_req) begin
                        last_grant_d <= pick_d;
                        if (pick_d) begin
                            state     <= D_BUSY;
                            addr_q    <= d_pmem_address;
                            wdata_q   <= d_pmem_wdata;
                            // A simultaneous read+write from the D-cache resolves as a write.
                            mem_read  <= ~d_pmem_write;
                            mem_write <= d_pmem_write;
                        end else begin
                            state     <= I_BUSY;
                            addr_q    <= i_pmem_address;
                            mem_read  <= 1'b1;
                            mem_write <= 1'b0;
                        end
                    end
                end
                I_BUSY, D_BUSY: begin
                    if (mem_resp) begin
                        state     <= RELEASE;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Response is only meaningful while the owner holds the port.
    assign i_pmem_resp  = (state == I_BUSY) & mem_resp;
    assign d_pmem_resp  = (state == D_BUSY) & mem_resp;
    assign i_pmem_rdata = mem_rdata;
    assign d_pmem_rdata = mem_rdata;

    assign mem_address  = addr_q;
    assign mem_wdata    = wdata_q;
    assign busy         = (state != IDLE);
    assign grant_d      = last_grant_d;

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed scenarios plus randomized request traffic
// checked against a transaction-level round-robin model.
module tb_cache_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk;
    logic          rst;
    logic          i_pmem_read;
    logic [AW-1:0] i_pmem_address;
    logic [LW-1:0] i_pmem_rdata;
    logic          i_pmem_resp;
    logic          d_pmem_read;
    logic          d_pmem_write;
    logic [AW-1:0] d_pmem_address;
    logic [LW-1:0] d_pmem_wdata;
    logic [LW-1:0] d_pmem_rdata;
    logic          d_pmem_resp;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata;
    logic          mem_resp;
    logic          busy;
    logic          grant_d;

    cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_resp       (mem_resp),
        .busy           (busy),
        .grant_d        (grant_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Transaction-level model: who is waiting, what they asked for, who went last.
    bit            i_pend;
    bit            d_pend;
    logic [AW-1:0] i_addr_m;
    logic [AW-1:0] d_addr_m;
    bit            d_wr_m;
    logic [LW-1:0] d_wdata_m;
    bit            last_served_d;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        for (int w = 0; w < LW / 32; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic raise_i(input logic [AW-1:0] addr);
        i_pmem_read    = 1'b1;
        i_pmem_address = addr;
        i_pend         = 1'b1;
        i_addr_m       = addr;
    endtask

    task automatic raise_d(input logic [AW-1:0] addr, input bit rd, input bit wr, input logic [LW-1:0] wd);
        d_pmem_read    = rd;
        d_pmem_write   = wr;
        d_pmem_address = addr;
        d_pmem_wdata   = wd;
        d_pend         = 1'b1;
        d_addr_m       = addr;
        d_wr_m         = wr;
        d_wdata_m      = wd;
    endtask

    // Called in an IDLE cycle with requests already driven; returns in the
    // IDLE cycle two cycles after the memory response.
    task automatic serve(input int lat, input bit disturb, input logic [LW-1:0] rd);
        bit            win_d;
        bit            ew;
        logic [AW-1:0] ea;
        logic [LW-1:0] ewd;
        @(negedge clk);
        chk("idle_before_grant", busy, 1'b0);
        win_d = d_pend && (!i_pend || !last_served_d);
        if (win_d) begin
            ea  = d_addr_m;
            ew  = d_wr_m;
            ewd = d_wdata_m;
        end else begin
            ea  = i_addr_m;
            ew  = 1'b0;
            ewd = '0;
        end
        last_served_d = win_d;
        @(posedge clk); #1;
        for (int k = 1; k <= lat; k++) begin
            mem_resp  = (k == lat);
            mem_rdata = rd;
            if (disturb && k == 1) begin
                if (win_d) begin
                    d_pmem_address = 32'hDEAD_BEE0;
                    d_pmem_wdata   = ~ewd;
                    d_pmem_read    = 1'b0;
                    d_pmem_write   = 1'b0;
                    d_pend         = 1'b0;
                end else begin
                    i_pmem_address = 32'hDEAD_BEE0;
                    i_pmem_read    = 1'b0;
                    i_pend         = 1'b0;
                end
            end
            @(negedge clk);
            chk("busy_in_txn", busy, 1'b1);
            chk("grant_d", grant_d, win_d);
            chk("mem_read", mem_read, !ew);
            chk("mem_write", mem_write, ew);
            chk("mem_address", mem_address, ea);
            if (ew) chk("mem_wdata", mem_wdata, ewd);
            chk("i_pmem_resp", i_pmem_resp, (k == lat) && !win_d);
            chk("d_pmem_resp", d_pmem_resp, (k == lat) && win_d);
            if (k == lat) begin
                chk("i_pmem_rdata", i_pmem_rdata, rd);
                chk("d_pmem_rdata", d_pmem_rdata, rd);
            end
            @(posedge clk); #1;
        end
        mem_resp  = $urandom_range(0, 1);
        mem_rdata = rand_line();
        if (win_d) begin
            d_pmem_read  = 1'b0;
            d_pmem_write = 1'b0;
            d_pend       = 1'b0;
        end else begin
            i_pmem_read = 1'b0;
            i_pend      = 1'b0;
        end
        @(negedge clk);
        chk("release_busy", busy, 1'b1);
        chk("release_mem_read", mem_read, 1'b0);
        chk("release_mem_write", mem_write, 1'b0);
        chk("release_i_resp", i_pmem_resp, 1'b0);
        chk("release_d_resp", d_pmem_resp, 1'b0);
        @(posedge clk); #1;
        mem_resp = 1'b0;
    endtask

    task automatic idle_spurious();
        mem_resp = 1'b1;
        @(negedge clk);
        chk("spur_busy", busy, 1'b0);
        chk("spur_i_resp", i_pmem_resp, 1'b0);
        chk("spur_d_resp", d_pmem_resp, 1'b0);
        @(posedge clk); #1;
        mem_resp = 1'b0;
        @(negedge clk);
        chk("spur_stays_idle", busy, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst            = 1'b1;
        i_pmem_read    = 1'b0;
        i_pmem_address = '0;
        d_pmem_read    = 1'b0;
        d_pmem_write   = 1'b0;
        d_pmem_address = '0;
        d_pmem_wdata   = '0;
        mem_rdata      = '0;
        mem_resp       = 1'b0;
        i_pend         = 1'b0;
        d_pend         = 1'b0;
        last_served_d  = 1'b0;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant_d", grant_d, 1'b0);
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_mem_write", mem_write, 1'b0);
        chk("rst_mem_address", mem_address, '0);
        chk("rst_mem_wdata", mem_wdata, '0);
        chk("rst_i_resp", i_pmem_resp, 1'b0);
        chk("rst_d_resp", d_pmem_resp, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        // I-only fill with a 3-cycle memory.
        raise_i(32'h0000_1000);
        serve(3, 1'b0, {32{8'hA5}});

        // D writeback with a 1-cycle memory.
        raise_d(32'h0000_2020, 1'b0, 1'b1, {8{32'h1234_5678}});
        serve(1, 1'b0, rand_line());

        // Contention: after an I then D history, ties alternate.
        raise_i(32'h0000_3000);
        raise_d(32'h0000_4000, 1'b1, 1'b0, '0);
        serve(2, 1'b0, rand_line());
        serve(2, 1'b0, rand_line());
        raise_i(32'h0000_3020);
        raise_d(32'h0000_4020, 1'b0, 1'b1, rand_line());
        serve(1, 1'b0, rand_line());
        serve(1, 1'b0, rand_line());

        // Address change and request drop while the D-cache owns the port.
        raise_d(32'h0000_5040, 1'b1, 1'b0, '0);
        serve(4, 1'b1, rand_line());

        // Illegal read+write from the D-cache resolves as a write.
        raise_d(32'h0000_6060, 1'b1, 1'b1, rand_line());
        serve(2, 1'b0, rand_line());

        idle_spurious();

        // Reset while a D writeback is in progress.
        raise_d(32'h0000_7000, 1'b0, 1'b1, rand_line());
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_reset_mem_write", mem_write, 1'b1);
        #2;
        mem_resp = 1'b1;
        rst      = 1'b1;
        #1;
        chk("async_rst_mem_write", mem_write, 1'b0);
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_d_resp", d_pmem_resp, 1'b0);
        chk("async_rst_grant_d", grant_d, 1'b0);
        mem_resp      = 1'b0;
        d_pmem_write  = 1'b0;
        d_pend        = 1'b0;
        last_served_d = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        raise_i(32'h0000_8000);
        raise_d(32'h0000_9000, 1'b1, 1'b0, '0);
        serve(1, 1'b0, rand_line());
        serve(1, 1'b0, rand_line());

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            if (!i_pend && $urandom_range(0, 1) == 1)
                raise_i($urandom & 32'hFFFF_FFE0);
            if (!d_pend && $urandom_range(0, 1) == 1) begin
                if ($urandom_range(0, 1) == 1)
                    raise_d($urandom & 32'hFFFF_FFE0, 1'b0, 1'b1, rand_line());
                else
                    raise_d($urandom & 32'hFFFF_FFE0, 1'b1, 1'b0, '0);
            end
            if (!i_pend && !d_pend)
                idle_spurious();
            else
                serve($urandom_range(1, 4), ($urandom_range(0, 3) == 0), rand_line());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
